adder_frame_engine: RTL and testbench
=====================================

ADDER_FRAME_ENGINE -- requirements
Module: adder_frame_engine

Interface
REQ-001 SHALL have parameter SEG_W, default 8: adder segment width in bits; legal values 4, 8, 16, 32; N = 32/SEG_W segments.
REQ-002 SHALL have port sys_clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset; state clears while rst=0.
REQ-004 SHALL have port frame_valid  input  1  one-cycle strobe: frame_in holds a complete received 8-byte frame.
REQ-005 SHALL have port frame_in  input  64  received frame; [63:32] = operand A, [31:0] = operand B.
REQ-006 SHALL have port result_ack  input  1  downstream transmit stage has consumed result.
REQ-007 SHALL have port result  output  32  sum presented to the transmit stage, most significant byte sent first.
REQ-008 SHALL have port result_valid  output  1  result is final and stable.
REQ-009 SHALL have port carry_out  output  1  carry out of bit 31 of the last addition.
REQ-010 SHALL have port busy  output  1  high in CALC and DONE.
REQ-011 SHALL have port overrun  output  1  sticky flag: a frame was dropped.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-013 SHALL, in IDLE, on frame_valid=1, latch A and B, clear the segment index and the internal carry, and go to CALC.
REQ-014 SHALL, in CALC, add one SEG_W-bit segment per cycle, LSB segment first, with the carry registered between segments (segment-serial ripple).
REQ-015 SHALL write each segment sum into the matching slice of result in the cycle it is computed.
REQ-016 SHALL, on the edge computing segment N-1, set carry_out, set result_valid=1 and go to DONE; latency is N edges after the edge sampling frame_valid (4 for SEG_W=8).
REQ-017 SHALL hold result, carry_out and result_valid stable in DONE until result_ack=1 is sampled.
REQ-018 SHALL, in DONE with result_ack=1 and frame_valid=0, clear result_valid and go to IDLE.
REQ-019 SHALL, in DONE with result_ack=1 and frame_valid=1 on the same edge, clear result_valid, latch the new frame and go directly to CALC.
REQ-020 SHALL ignore frame_valid in CALC, and in DONE without result_ack, and set overrun=1 in those cases.
REQ-021 SHALL ignore result_ack outside DONE.
REQ-022 SHALL keep result and carry_out at their last values in IDLE; only a new frame or reset changes them.
REQ-023 SHALL treat all arithmetic as unsigned 32-bit with wrap-around modulo 2^32, unless configured otherwise per REQ-028.

Reset
REQ-024 SHALL, while rst=0, force: state IDLE, result=0, result_valid=0, carry_out=0, busy=0, overrun=0, segment index=0, latched operands=0.
REQ-025 SHALL abandon any CALC or DONE operation on reset without producing result_valid; the first frame after release behaves as from power-up.
REQ-026 SHALL clear overrun only through reset.

Configuration
REQ-027 SHALL use the macro ADDER_SATURATE_EN to select overflow behaviour.
REQ-028 SHALL, with ADDER_SATURATE_EN defined, replace result with 0xFFFF_FFFF when the final carry is 1, in the same edge result_valid rises; carry_out still reports 1.
REQ-029 SHALL, without ADDER_SATURATE_EN, present the wrapped sum, with no saturation logic compiled in.

Verification
REQ-030 SHALL cover: SEG_W=8, frame_in=0x0000_00FF_0000_0001 -> result=0x0000_0100, carry_out=0, result_valid high 4 edges after frame_valid.
REQ-031 SHALL cover: frame_in=0xFFFF_FFFF_0000_0001 -> result=0x0000_0000, carry_out=1 without macro; result=0xFFFF_FFFF, carry_out=1 with ADDER_SATURATE_EN.
REQ-032 SHALL cover: second frame_valid 2 cycles after the first -> first result 0x0000_0100 delivered unchanged, overrun=1, no second result_valid.
REQ-033 SHALL cover: in DONE, result_ack and frame_valid on the same edge with frame 0x0000_0002_0000_0003 -> result_valid drops for N cycles, then result=0x0000_0005.
REQ-034 SHALL cover: rst=0 asserted mid-CALC -> all outputs 0 immediately (asynchronous), state IDLE, no result_valid after rst=1.
REQ-035 SHALL cover: SEG_W=4 and SEG_W=32, frame_in=0x1234_5678_1111_1111 -> result=0x2345_6789, latency 8 and 1 edges respectively.

Source files
------------

// File: rtl/adder_frame_engine.sv
// Frame-driven 32-bit adder: A/B from one 64-bit frame, summed segment-serially.
// Ports: sys_clk, rst (async low), frame_valid/frame_in in; result_ack in;
// result/result_valid/carry_out/busy/overrun out. Option macro: ADDER_SATURATE_EN.
module adder_frame_engine #(
  parameter int SEG_W = 8
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        frame_valid,
  input  logic [63:0] frame_in,
  input  logic        result_ack,
  output logic [31:0] result,
  output logic        result_valid,
  output logic        carry_out,
  output logic        busy,
  output logic        overrun
);

  localparam int N  = 32 / SEG_W;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [31:0]    r_a;
  logic [31:0]    r_b;
  logic [31:0]    r_result;
  logic [IW-1:0]  r_idx;
  logic           r_carry;
  logic           r_cout;
  logic           r_overrun;

  logic [SEG_W-1:0] w_seg_a;
  logic [SEG_W-1:0] w_seg_b;
  logic [SEG_W:0]   w_sum;
  logic             w_last;
  logic             w_accept;
  logic             w_drop;

  assign w_seg_a = r_a[int'(r_idx)*SEG_W +: SEG_W];
  assign w_seg_b = r_b[int'(r_idx)*SEG_W +: SEG_W];
  assign w_sum   = {1'b0, w_seg_a} + {1'b0, w_seg_b}
                 + {{SEG_W{1'b0}}, r_carry};
  assign w_last  = (r_idx == IW'(N - 1));

  // A frame is taken in IDLE, or in DONE when the ack frees the slot
  // on the same edge; anywhere else it is dropped.
  assign w_accept = frame_valid &&
    ((r_state == IDLE) || ((r_state == DONE) && result_ack));
  assign w_drop = frame_valid &&
    ((r_state == CALC) || ((r_state == DONE) && !result_ack));

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (frame_valid) w_next = CALC;
      CALC: if (w_last) w_next = DONE;
      DONE: if (result_ack) w_next = frame_valid ? CALC : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    result       = r_result;
    carry_out    = r_cout;
    overrun      = r_overrun;
    result_valid = (r_state == DONE);
    busy         = (r_state != IDLE);
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_result  <= '0;
      r_idx     <= '0;
      r_carry   <= 1'b0;
      r_cout    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_drop) r_overrun <= 1'b1;
      if (w_accept) begin
        r_a     <= frame_in[63:32];
        r_b     <= frame_in[31:0];
        r_idx   <= '0;
        r_carry <= 1'b0;
      end else if (r_state == CALC) begin
        r_result[int'(r_idx)*SEG_W +: SEG_W] <= w_sum[SEG_W-1:0];
        r_carry <= w_sum[SEG_W];
        if (w_last) begin
          r_cout <= w_sum[SEG_W];
`ifdef ADDER_SATURATE_EN
          // Overflow clamps the whole word on the final segment edge.
          if (w_sum[SEG_W]) r_result <= '1;
`endif
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_frame_engine.sv
// Scoreboard bench for adder_frame_engine (SEG_W=8 main, 4 and 32 latency).
// Build with +define+ADDER_SATURATE_EN to check the saturating variant.
module tb_adder_frame_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        fv = 1'b0;
  logic [63:0] fin = '0;
  logic        ack = 1'b0;
  logic [31:0] res8;
  logic        rv8, co8, busy8, ov8;

  logic        fv_w = 1'b0;
  logic [63:0] fin_w = '0;
  logic        ack_w = 1'b0;
  logic [31:0] res4, res32;
  logic        rv4, co4, busy4, ov4;
  logic        rv32, co32, busy32, ov32;

`ifdef ADDER_SATURATE_EN
  localparam logic [31:0] OVF = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] OVF = 32'h0000_0000;
`endif

  adder_frame_engine #(.SEG_W(8)) dut8 (
    .sys_clk(clk), .rst(rst_n), .frame_valid(fv), .frame_in(fin),
    .result_ack(ack), .result(res8), .result_valid(rv8),
    .carry_out(co8), .busy(busy8), .overrun(ov8));

  adder_frame_engine #(.SEG_W(4)) dut4 (
    .sys_clk(clk), .rst(rst_n), .frame_valid(fv_w), .frame_in(fin_w),
    .result_ack(ack_w), .result(res4), .result_valid(rv4),
    .carry_out(co4), .busy(busy4), .overrun(ov4));

  adder_frame_engine #(.SEG_W(32)) dut32 (
    .sys_clk(clk), .rst(rst_n), .frame_valid(fv_w), .frame_in(fin_w),
    .result_ack(ack_w), .result(res32), .result_valid(rv32),
    .carry_out(co32), .busy(busy32), .overrun(ov32));

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] r;
    logic        c;
    int          e;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%h req=%h", name, act, req);
    end
  endtask

  // Monitor: pops on each rising result_valid, checks hold while high.
  logic [31:0] hr;
  logic        hc;
  bit          pv = 1'b0;
  always @(negedge clk) begin
    if (rv8 && !pv) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid act=%h req=none", res8);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", res8, e.r);
        chk("carry", {31'd0, co8}, {31'd0, e.c});
        chk("latency_edge", cyc, e.e);
      end
      hr = res8;
      hc = co8;
    end else if (rv8 && pv) begin
      chk("hold_result", res8, hr);
      chk("hold_carry", {31'd0, co8}, {31'd0, hc});
    end
    pv = rv8;
  end

  task automatic send(input logic [63:0] f, input bit acc,
                      input logic [31:0] r, input logic c);
    @(negedge clk);
    fv = 1'b1;
    fin = f;
    @(negedge clk);
    fv = 1'b0;
    if (acc) sb.push_back('{r, c, cyc + 4});
  endtask

  task automatic wait_valid();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (rv8) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!found) begin
      total++;
      bad++;
      $display("FAIL valid_timeout act=0 req=1");
    end
  endtask

  task automatic ack_result();
    wait_valid();
    repeat (2) @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  int lat4, lat32, se;
  logic [31:0] r4, r32;

  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_result", res8, 32'h0);
    chk("rst_valid", {31'd0, rv8}, 32'd0);
    chk("rst_busy", {31'd0, busy8}, 32'd0);
    chk("rst_overrun", {31'd0, ov8}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    send(64'h0000_00FF_0000_0001, 1'b1, 32'h0000_0100, 1'b0);
    chk("busy_calc", {31'd0, busy8}, 32'd1);
    ack_result();

    send(64'hFFFF_FFFF_0000_0001, 1'b1, OVF, 1'b1);
    ack_result();

    send(64'h1234_5678_1111_1111, 1'b1, 32'h2345_6789, 1'b0);
    ack_result();

    // Ack and new frame on the same edge in DONE.
    send(64'h0000_00FF_0000_0001, 1'b1, 32'h0000_0100, 1'b0);
    wait_valid();
    ack = 1'b1;
    fv = 1'b1;
    fin = 64'h0000_0002_0000_0003;
    sb.push_back('{32'h0000_0005, 1'b0, cyc + 5});
    @(negedge clk);
    ack = 1'b0;
    fv = 1'b0;
    chk("b2b_valid_drop", {31'd0, rv8}, 32'd0);
    chk("b2b_busy", {31'd0, busy8}, 32'd1);
    ack_result();
    chk("no_overrun_yet", {31'd0, ov8}, 32'd0);

    // Second frame two edges into CALC is dropped.
    send(64'h0000_00FF_0000_0001, 1'b1, 32'h0000_0100, 1'b0);
    send(64'h0000_0009_0000_0009, 1'b0, 32'h0, 1'b0);
    ack_result();
    chk("overrun_set", {31'd0, ov8}, 32'd1);
    repeat (12) @(negedge clk);
    chk("overrun_sticky", {31'd0, ov8}, 32'd1);
    chk("idle_keep_result", res8, 32'h0000_0100);

    // Asynchronous reset in the middle of CALC.
    send(64'h0000_0001_0000_0001, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_result", res8, 32'h0);
    chk("arst_valid", {31'd0, rv8}, 32'd0);
    chk("arst_carry", {31'd0, co8}, 32'd0);
    chk("arst_busy", {31'd0, busy8}, 32'd0);
    chk("arst_overrun", {31'd0, ov8}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_idle", {31'd0, busy8}, 32'd0);
    send(64'h0000_0003_0000_0004, 1'b1, 32'h0000_0007, 1'b0);
    ack_result();

    // Segment width 4 and 32 latency.
    lat4 = -1;
    lat32 = -1;
    r4 = '0;
    r32 = '0;
    @(negedge clk);
    fv_w = 1'b1;
    fin_w = 64'h1234_5678_1111_1111;
    @(negedge clk);
    fv_w = 1'b0;
    se = cyc;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (rv4 && lat4 < 0) begin
        lat4 = cyc - se;
        r4 = res4;
      end
      if (rv32 && lat32 < 0) begin
        lat32 = cyc - se;
        r32 = res32;
      end
    end
    chk("lat_seg4", lat4, 8);
    chk("res_seg4", r4, 32'h2345_6789);
    chk("lat_seg32", lat32, 1);
    chk("res_seg32", r32, 32'h2345_6789);
    chk("carry_seg32", {31'd0, co32}, 32'd0);

    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog act=running req=finished");
    $fatal(1, "timeout");
  end

endmodule
